// File: rtl/uart_rx_cfg.sv
// UART receive-side config port: deserialises RX bytes and parses five hex chars plus CR/LF
// into a 20-bit value. Contains the byte-level receiver uart_rx and the frame parser uart_rx_cfg.

module uart_rx #(
  parameter int CLK_FRE   = 100,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  input  logic       rx_pin
);
  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | timing to the middle of the start bit
  // S_DATA   | sampling 8 data bits, LSB first, at mid-bit
  // S_STOP   | timing to the middle of the stop bit
  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW    = $clog2(CYCLE + 1);
  localparam logic [CW-1:0] T_FULL = CW'(CYCLE - 1);
  localparam logic [CW-1:0] T_HALF = CW'(CYCLE / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          s1_q, s2_q, s3_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_data_ready;
    case (state_q)
      S_IDLE: begin
        if (s3_q && !s2_q) begin
          state_d = S_START;
          tmr_d   = T_HALF;
        end
      end
      S_START: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else if (!s2_q) begin
          state_d = S_DATA;
          tmr_d   = T_FULL;
          bit_d   = 3'd0;
        end else state_d = S_IDLE;
      end
      S_DATA: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else begin
          shift_d = {s2_q, shift_q[7:1]};
          tmr_d   = T_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a start bit immediately after is not missed.
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else begin
          state_d = S_IDLE;
          if (s2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      s1_q    <= rx_pin;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
endmodule

module uart_rx_cfg #(
  parameter int CLK_FRE     = 100,
  parameter int BAUD_RATE   = 115200,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [19:0] cfg_data,
  output logic        cfg_valid,
  output logic        cfg_err,
  output logic        busy
);
  // state     | meaning
  // IDLE      | between frames; CR/LF ignored
  // RECV      | collecting hex characters 1..4
  // WAIT_TERM | five hex chars held, expecting CR/LF
  // FLUSH     | rejected frame, discarding up to next CR/LF
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_TERM, FLUSH} state_t;

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_rx #(
    .CLK_FRE  (CLK_FRE),
    .BAUD_RATE(BAUD_RATE)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_byte),
    .rx_data_valid(rx_valid),
    .rx_data_ready(1'b1),
    .rx_pin       (uart_rx)
  );

  logic       is_hex, is_term;
  logic [3:0] nib;

  always_comb begin
    is_hex  = 1'b0;
    nib     = 4'd0;
    is_term = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0] + 4'd9;
    end
  end

  state_t        state_q, state_d;
  logic [19:0]   sh_q, sh_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [19:0]   cfg_data_q, cfg_data_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic          cfg_err_q, cfg_err_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = 1'b0;
    cfg_err_d   = 1'b0;
    if (state_q == IDLE || rx_valid) idle_d = '0;
    else if (idle_q != TO_MAX)       idle_d = idle_q + 1'b1;
    else                             idle_d = idle_q;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (is_hex) begin
            sh_d    = {16'd0, nib};
            cnt_d   = 3'd1;
            state_d = RECV;
          end else if (!is_term) begin
            cfg_err_d = 1'b1;
            state_d   = FLUSH;
          end
        end
        RECV: begin
          if (is_hex) begin
            sh_d  = {sh_q[15:0], nib};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4) state_d = WAIT_TERM;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = is_term ? IDLE : FLUSH;
          end
        end
        WAIT_TERM: begin
          if (is_term) begin
            cfg_data_d  = sh_q;
            cfg_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = FLUSH;
          end
        end
        FLUSH: begin
          if (is_term) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && idle_q == TO_MAX) begin
      // A flushed frame already reported its error, so it times out silently.
      cfg_err_d = (state_q != FLUSH);
      state_d   = IDLE;
    end
    if (state_d == IDLE) cnt_d = 3'd0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames at 16 clk/bit, pulse counting and data checks.

module tb_uart_rx_cfg;
  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [19:0] cfg_data;
  logic        cfg_valid, cfg_err, busy;

  int n_vec = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  logic rxv_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FRE    (1),
    .BAUD_RATE  (62500),
    .TIMEOUT_CYC(2000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (rx),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counting plus the one-clock latency from the consumed byte to cfg_valid.
  always @(negedge clk) begin
    if (cfg_valid) begin
      n_valid++;
      chk("valid_latency", {31'd0, rxv_prev}, 32'd1);
    end
    if (cfg_err) n_err++;
    if (cfg_valid && cfg_err) n_both++;
    rxv_prev = dut.rx_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic clr();
    n_valid = 0;
    n_err   = 0;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_data", {12'd0, cfg_data}, 32'h0);
    chk("rst_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    clr();
    send_str("1A2B3"); send_byte(8'h0D); settle();
    chk("t1_data", {12'd0, cfg_data}, 32'h1A2B3);
    chk("t1_nvalid", n_valid, 1);
    chk("t1_nerr", n_err, 0);

    clr();
    send_str("abcde"); send_byte(8'h0A); send_byte(8'h0A); settle();
    chk("t2_data", {12'd0, cfg_data}, 32'hABCDE);
    chk("t2_nvalid", n_valid, 1);
    chk("t2_nerr", n_err, 0);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    clr();
    send_str("12G45"); send_byte(8'h0D); settle();
    chk("t3_nerr", n_err, 1);
    chk("t3_nvalid", n_valid, 0);
    chk("t3_data", {12'd0, cfg_data}, 32'hABCDE);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    clr();
    send_str("00001"); send_byte(8'h0D); settle();
    chk("t3b_data", {12'd0, cfg_data}, 32'h00001);
    chk("t3b_nvalid", n_valid, 1);
    chk("t3b_nerr", n_err, 0);

    clr();
    send_str("123"); send_byte(8'h0D); settle();
    chk("t4_short_nerr", n_err, 1);
    clr();
    send_str("123456"); send_byte(8'h0D); settle();
    chk("t4_long_nerr", n_err, 1);
    chk("t4_nvalid", n_valid, 0);
    chk("t4_data", {12'd0, cfg_data}, 32'h00001);
    chk("t4_busy", {31'd0, busy}, 32'd0);

    clr();
    send_str("12");
    chk("t5_busy_recv", {31'd0, busy}, 32'd1);
    repeat (3000) @(negedge clk);
    chk("t5_to_nerr", n_err, 1);
    chk("t5_to_busy", {31'd0, busy}, 32'd0);
    clr();
    send_str("FFFFF"); send_byte(8'h0D); settle();
    chk("t5_data", {12'd0, cfg_data}, 32'hFFFFF);
    chk("t5_nvalid", n_valid, 1);

    clr();
    send_str("1234");
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_data", {12'd0, cfg_data}, 32'h0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_npulse", n_valid + n_err, 0);
    send_str("54321"); send_byte(8'h0D); settle();
    chk("t6b_data", {12'd0, cfg_data}, 32'h54321);

    clr();
    send_str("fEdCb"); send_byte(8'h0D); settle();
    chk("t7_data", {12'd0, cfg_data}, 32'hFEDCB);
    clr();
    send_str("`9/@:"); send_byte(8'h0D); settle();
    chk("t7_bad_nerr", n_err, 1);
    chk("t7_bad_data", {12'd0, cfg_data}, 32'hFEDCB);
    clr();
    send_str("9a0F6"); send_byte(8'h0D); settle();
    chk("t7b_data", {12'd0, cfg_data}, 32'h9A0F6);

    chk("never_both", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Receive-side configuration port: deserialises bytes from the UART RX pin and parses a frame of exactly five ASCII hex characters followed by CR or LF into a 20-bit value. Frame format is the one our transmit-side config path emits: most significant nibble first. A good frame pulses `cfg_valid` and updates `cfg_data`. A malformed or stalled frame pulses `cfg_err` and leaves `cfg_data` unchanged. The block sits between the board RX pin and the register/config logic that consumes `cfg_data`.

## Interface
- `CLK_FRE`, 100, clock frequency in MHz; passed to `uart_rx`.
- `BAUD_RATE`, 115200, line rate; passed to `uart_rx`.
- `TIMEOUT_CYC`, 1000000, allowed idle clk cycles between bytes inside a frame (10 ms at 100 MHz).
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `uart_rx`  input  1  serial RX line, idle high.
- `cfg_data`  output  20  last successfully received value.
- `cfg_valid`  output  1  one-cycle pulse, new `cfg_data`.
- `cfg_err`  output  1  one-cycle pulse, frame rejected.
- `busy`  output  1  high whenever state != IDLE.

## Operation
- Instantiates `uart_rx` (ports `clk`, `rst_n`, `rx_data[7:0]`, `rx_data_valid`, `rx_data_ready`, `rx_pin`) with `rx_data_ready` tied to 1.
  - A byte is consumed on every cycle with `rx_data_valid` high.
- Byte classes, combinational:
  - hex: 0x30-0x39 → 0-9; 0x41-0x46 and 0x61-0x66 → A-F (case-insensitive).
  - term: 0x0D or 0x0A.
  - bad: everything else.
- Storage:
  - shift register `sh[19:0]`; a hex byte does `sh <= {sh[15:0], nibble}`.
  - char counter 0..5.
- States and transitions on a consumed byte:
  - IDLE:
    - hex → load nibble, cnt=1, go to RECV.
    - term → ignored, stay in IDLE (permits CRLF and blank lines).
    - bad → `cfg_err`, go to FLUSH.
  - RECV:
    - hex → shift, cnt+1; on reaching cnt=5 go to WAIT_TERM.
    - term → `cfg_err` (short frame), go to IDLE.
    - bad → `cfg_err`, go to FLUSH.
  - WAIT_TERM:
    - term → `cfg_data <= sh`, `cfg_valid`, go to IDLE.
    - hex (long frame) or bad → `cfg_err`, go to FLUSH.
  - FLUSH:
    - term → go to IDLE, no pulse.
    - any other byte is discarded.
- Timeout:
  - Idle counter clears on every consumed byte and is held at 0 in IDLE.
  - It increments each cycle in the other states.
  - On reaching `TIMEOUT_CYC`: from RECV or WAIT_TERM → `cfg_err`, go to IDLE; from FLUSH → go to IDLE silently.
  - If a byte arrives on the same cycle the count reaches `TIMEOUT_CYC`, the byte wins.
- At most one error pulse per frame. `cfg_valid` and `cfg_err` are never high together.

## Timing
- Reset values: `cfg_data`=0, `cfg_valid`=0, `cfg_err`=0, `busy`=0, state IDLE, counters 0.
- Reset asserted mid-frame discards the partial frame and produces no pulse.
- One bit period is `CLK_FRE*1e6/BAUD_RATE` clocks (868 at defaults).
- `cfg_valid` and `cfg_err` are registered:
  - Each goes high for exactly 1 clk, on the edge after the cycle the triggering byte is consumed.
  - `cfg_data` changes on that same edge and holds until the next good frame.
- `busy` follows state with 1 clk registered latency relative to the consumed byte.
- Timeout counter width is `$clog2(TIMEOUT_CYC+1)`; it saturates and never wraps.
- Back-to-back bytes (stop bit followed immediately by the next start bit) are handled without loss; no internal buffering is needed because decisions complete in 1 clk.

## Test plan
- Serial "1A2B3\r" at 115200 → `cfg_data`=0x1A2B3; exactly one `cfg_valid` pulse 1 clk after the CR byte's `rx_data_valid`; `cfg_err` stays 0.
- "abcde\n\n" → `cfg_data`=0xABCDE, one `cfg_valid`; the second LF is ignored; `busy` ends at 0.
- "12G45\r" then "00001\r":
  - `cfg_err` pulses once at 'G' and `cfg_data` is unchanged.
  - The remaining characters are flushed.
  - The second frame gives `cfg_data`=0x00001.
- "123\r" then "123456\r" → one `cfg_err` for each frame (at the CR, then at '6'); no `cfg_valid`; `cfg_data` keeps its prior value.
- With `TIMEOUT_CYC`=2000: send "12", then idle for 3000 clk → one `cfg_err`, `busy` falls; then "FFFFF\r" → `cfg_data`=0xFFFFF.
- Send "1234", pulse `rst_n` low for 5 clk → all outputs return to their reset values with no pulse; then "54321\r" → `cfg_data`=0x54321.
